// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute path: opcodes, NZCV bit positions
// and the buffered result-entry record used by the result stage.
package alu_pkg;

  // Entry field widths; alu_result_stage parameters N/REG_W must match these.
  localparam int ENTRY_N     = 32;
  localparam int ENTRY_REG_W = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [ENTRY_N-1:0]     result;
    logic [ENTRY_REG_W-1:0] dest;
    logic [3:0]             flags;
    logic                   set_flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_stage.sv
// Two-entry (main + skid) result buffer behind the combinational ALU, with
// NZCV status commit when an entry retires to writeback.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [N-1:0]     in_result,
  input  logic             in_c,
  input  logic             in_o,
  input  logic             in_n,
  input  logic             in_z,
  input  logic             in_set_flags,
  input  logic [REG_W-1:0] in_dest,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [REG_W-1:0] out_dest,
  output logic [3:0]       out_flags,
  output logic [3:0]       status_flags,
  output logic [1:0]       occupancy
);

  // Multiply and divide produce no meaningful carry/overflow, so C and V are cleared.
  function automatic logic [3:0] capture_flags(input logic [2:0] op,
                                               input logic n, input logic z,
                                               input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    if (op == OP_MUL || op == OP_DIV) begin
      f[FLAG_C] = 1'b0;
      f[FLAG_V] = 1'b0;
    end
    return f;
  endfunction

  alu_entry_t cap_entry_p0;
  alu_entry_t m_entry_p1;
  alu_entry_t s_entry_p1;
  logic       m_vld_p1;
  logic       s_vld_p1;
  logic       in_ready_p1;
  logic [3:0] status_p1;

  logic accept;
  logic retire;
  logic m_vld_nxt;
  logic s_vld_nxt;
  logic m_load_cap;
  logic m_load_skid;
  logic s_load;

  // ---- p0: capture the ALU outputs into an entry record ----
  always_comb begin
    cap_entry_p0           = '0;
    cap_entry_p0.result    = in_result;
    cap_entry_p0.dest      = in_dest;
    cap_entry_p0.flags     = capture_flags(in_opcode, in_n, in_z, in_c, in_o);
    cap_entry_p0.set_flags = in_set_flags;
  end

  assign accept = in_valid && in_ready_p1;
  assign retire = m_vld_p1 && out_ready;

  // A full skid register always drains into main first, keeping FIFO order.
  always_comb begin
    m_vld_nxt   = m_vld_p1;
    s_vld_nxt   = s_vld_p1;
    m_load_cap  = 1'b0;
    m_load_skid = 1'b0;
    s_load      = 1'b0;
    if (retire) begin
      if (s_vld_p1) begin
        m_load_skid = 1'b1;
        s_vld_nxt   = 1'b0;
      end else if (accept) begin
        m_load_cap  = 1'b1;
      end else begin
        m_vld_nxt   = 1'b0;
      end
    end else if (accept) begin
      if (m_vld_p1) begin
        s_load    = 1'b1;
        s_vld_nxt = 1'b1;
      end else begin
        m_load_cap = 1'b1;
        m_vld_nxt  = 1'b1;
      end
    end
  end

  // ---- p1: buffered entries, handshake state and status register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_p1    <= 1'b0;
      s_vld_p1    <= 1'b0;
      in_ready_p1 <= 1'b0;
      status_p1   <= '0;
    end else begin
      m_vld_p1    <= m_vld_nxt;
      s_vld_p1    <= s_vld_nxt;
      in_ready_p1 <= !s_vld_nxt;
      if (retire && m_entry_p1.set_flags)
        status_p1 <= m_entry_p1.flags;
    end
  end

  // Main entry drives the outputs directly, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst)
      m_entry_p1 <= '0;
    else if (m_load_cap)
      m_entry_p1 <= cap_entry_p0;
    else if (m_load_skid)
      m_entry_p1 <= s_entry_p1;
  end

  always_ff @(posedge clk) begin
    if (s_load)
      s_entry_p1 <= cap_entry_p0;
  end

  assign in_ready     = in_ready_p1;
  assign out_valid    = m_vld_p1;
  assign out_result   = m_entry_p1.result;
  assign out_dest     = m_entry_p1.dest;
  assign out_flags    = m_entry_p1.flags;
  assign status_flags = status_p1;
  assign occupancy    = {1'b0, m_vld_p1} + {1'b0, s_vld_p1};

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic against
// a depth-2 FIFO reference model with an NZCV status register.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [31:0] in_result;
  logic        in_c, in_o, in_n, in_z;
  logic        in_set_flags;
  logic [4:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic [3:0]  out_flags;
  logic [3:0]  status_flags;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  alu_result_stage #(.N(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_c(in_c), .in_o(in_o), .in_n(in_n), .in_z(in_z),
    .in_set_flags(in_set_flags), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_flags(out_flags),
    .status_flags(status_flags), .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  dest;
    logic [3:0]  flags;
    logic        sf;
  } exp_t;

  exp_t        mq[$];
  logic [3:0]  m_status;
  logic        m_ready;
  bit          last_acc;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: borrow-style carry for subtract, signed overflow for add/sub.
  task automatic drive_alu(input logic v, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic sf, input logic [4:0] d);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c, o;
    c = 1'b0; o = 1'b0;
    case (op)
      3'b000: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32];
                    o = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin r = a - b; c = (a < b); o = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: begin r = a * b; c = 1'b1; o = 1'b1; end
      3'b101: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; c = 1'b1; o = 1'b1; end
      default: r = a ^ b;
    endcase
    in_valid = v; in_opcode = op; in_result = r;
    in_c = c; in_o = o; in_n = r[31]; in_z = (r == 0);
    in_set_flags = sf; in_dest = d;
  endtask

  // One clock edge; the model follows the FIFO rules using pre-edge inputs.
  task automatic cycle();
    bit   acc, ret;
    exp_t e;
    acc = in_valid && m_ready && !rst;
    ret = (mq.size() > 0) && out_ready && !rst;
    e.result = in_result;
    e.dest   = in_dest;
    e.flags  = {in_n, in_z, in_c, in_o};
    if (in_opcode == 3'b010 || in_opcode == 3'b101) e.flags[1:0] = 2'b00;
    e.sf = in_set_flags;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_status = 4'b0;
      m_ready  = 1'b0;
    end else begin
      if (ret) begin
        if (mq[0].sf) m_status = mq[0].flags;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(e);
      m_ready = (mq.size() < 2);
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, {63'b0, out_valid}, {63'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk({tag, ".out_result"}, {32'b0, out_result}, {32'b0, mq[0].result});
      chk({tag, ".out_dest"},   {59'b0, out_dest},   {59'b0, mq[0].dest});
      chk({tag, ".out_flags"},  {60'b0, out_flags},  {60'b0, mq[0].flags});
    end
    chk({tag, ".occupancy"}, {62'b0, occupancy}, 64'(mq.size()));
    chk({tag, ".in_ready"},  {63'b0, in_ready},  {63'b0, m_ready});
    chk({tag, ".status"},    {60'b0, status_flags}, {60'b0, m_status});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".out_valid"},  {63'b0, out_valid}, 64'd0);
    chk({tag, ".occupancy"},  {62'b0, occupancy}, 64'd0);
    chk({tag, ".status"},     {60'b0, status_flags}, 64'd0);
    chk({tag, ".in_ready"},   {63'b0, in_ready}, 64'd0);
    chk({tag, ".out_result"}, {32'b0, out_result}, 64'd0);
    chk({tag, ".out_dest"},   {59'b0, out_dest}, 64'd0);
    chk({tag, ".out_flags"},  {60'b0, out_flags}, 64'd0);
  endtask

  initial begin
    logic        src_v;
    logic [2:0]  src_op;
    logic [31:0] src_r;
    logic [3:0]  src_f;
    logic        src_sf;
    logic [4:0]  src_d;
    logic [2:0]  ops [4];
    checks = 0; errors = 0;
    m_status = 4'b0; m_ready = 1'b0; last_acc = 1'b0;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b101;

    rst = 1'b1; out_ready = 1'b0;
    drive_alu(1'b1, 3'b000, 32'd5, 32'd6, 1'b1, 5'd1);
    cycle(); cycle();
    check_reset("reset");
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    check_model("post_reset");
    chk("post_reset.in_ready_high", {63'b0, in_ready}, 64'd1);

    // Basic capture: 32 - 32 with flags committed.
    out_ready = 1'b1;
    drive_alu(1'b1, 3'b001, 32'd32, 32'd32, 1'b1, 5'd3);
    cycle();
    check_model("sub");
    chk("sub.result", {32'b0, out_result}, 64'd0);
    chk("sub.flags",  {60'b0, out_flags}, 64'b0100);
    chk("sub.dest",   {59'b0, out_dest}, 64'd3);
    in_valid = 1'b0;
    cycle();
    chk("sub.status", {60'b0, status_flags}, 64'b0100);

    // Back-pressure: three adds, third held by the source until space frees.
    out_ready = 1'b0;
    drive_alu(1'b1, 3'b000, 32'd1, 32'd1, 1'b0, 5'd4); cycle(); check_model("bp1");
    drive_alu(1'b1, 3'b000, 32'd2, 32'd2, 1'b0, 5'd5); cycle(); check_model("bp2");
    chk("bp2.occupancy", {62'b0, occupancy}, 64'd2);
    chk("bp2.in_ready",  {63'b0, in_ready}, 64'd0);
    drive_alu(1'b1, 3'b000, 32'd3, 32'd3, 1'b0, 5'd6);
    cycle(); check_model("bp_hold1");
    cycle(); check_model("bp_hold2");
    chk("bp_hold.result", {32'b0, out_result}, 64'd2);
    out_ready = 1'b1;
    cycle(); check_model("bp_rel1");
    chk("bp_rel1.result", {32'b0, out_result}, 64'd4);
    cycle(); check_model("bp_rel2");
    chk("bp_rel2.result", {32'b0, out_result}, 64'd6);
    in_valid = 1'b0;
    cycle(); check_model("bp_drain");

    // Multiply masks C and V even though the ALU asserts them.
    drive_alu(1'b1, 3'b010, 32'd100, 32'd2, 1'b1, 5'd7);
    cycle(); check_model("mul");
    chk("mul.result", {32'b0, out_result}, 64'd200);
    chk("mul.flags",  {60'b0, out_flags}, 64'b0000);

    // Carry-out add committed, then a divide that leaves the status alone.
    drive_alu(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd8);
    cycle(); check_model("carry");
    chk("carry.flags", {60'b0, out_flags}, 64'b0110);
    drive_alu(1'b1, 3'b101, 32'd50, 32'd3, 1'b0, 5'd9);
    cycle(); check_model("div");
    chk("div.result", {32'b0, out_result}, 64'd16);
    in_valid = 1'b0;
    cycle(); check_model("div_retired");
    chk("div.status", {60'b0, status_flags}, 64'b0110);

    // Simultaneous retire and accept with only M occupied.
    out_ready = 1'b0;
    drive_alu(1'b1, 3'b000, 32'd10, 32'd20, 1'b0, 5'd10); cycle(); check_model("sim1");
    out_ready = 1'b1;
    drive_alu(1'b1, 3'b001, 32'd50, 32'd8, 1'b0, 5'd11); cycle(); check_model("sim2");
    chk("sim.occupancy", {62'b0, occupancy}, 64'd1);
    chk("sim.result", {32'b0, out_result}, 64'd42);

    // Reset with both entries held.
    out_ready = 1'b0;
    drive_alu(1'b1, 3'b000, 32'd7, 32'd7, 1'b1, 5'd12); cycle(); check_model("rfill");
    chk("rfill.occupancy", {62'b0, occupancy}, 64'd2);
    out_ready = 1'b1;
    rst = 1'b1;
    cycle();
    check_reset("mid_reset");
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    chk("mid_reset.in_ready_rise", {63'b0, in_ready}, 64'd1);
    check_model("mid_reset_after");

    // Random traffic; the source holds an offered entry until it is accepted.
    src_v = 1'b0; src_op = 3'b000; src_r = '0; src_f = '0; src_sf = 1'b0; src_d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!src_v || last_acc) begin
        src_v  = ($urandom_range(0, 9) < 7);
        src_op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                             : ops[$urandom_range(0, 3)];
        src_r  = $urandom;
        src_f  = 4'($urandom);
        src_sf = 1'($urandom);
        src_d  = 5'($urandom);
      end
      in_valid = src_v; in_opcode = src_op; in_result = src_r;
      in_n = src_f[3]; in_z = src_f[2]; in_c = src_f[1]; in_o = src_f[0];
      in_set_flags = src_sf; in_dest = src_d;
      out_ready = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 79) == 0);
      cycle();
      if (rst) check_reset("rnd_reset");
      else     check_model("rnd");
    end

    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Pipeline register and flag-commit stage directly downstream of the combinational `alu` (N-bit, 3-bit opcode, C/O/N/Z flags) in the vector processor execute path.
- Captures the ALU result, flags, opcode and destination tag under a valid/ready handshake.
- Buffers up to two entries so the ALU side never loses data under back-pressure.
- Commits flags to an architectural NZCV status register when an entry retires to writeback.

Parameters:
- N, 32, datapath width; must match the upstream alu instance.
- REG_W, 5, destination register index width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  ALU output holds a valid operation this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- in_opcode  input  3  opcode driven to the alu (000 add, 001 sub, 010 mul, 101 div).
- in_result  input  N  alu result.
- in_c  input  1  alu C_Flag.
- in_o  input  1  alu O_Flag.
- in_n  input  1  alu N_Flag.
- in_z  input  1  alu Z_Flag.
- in_set_flags  input  1  operation updates the status register on retire.
- in_dest  input  REG_W  destination register tag.
- out_valid  output  1  out_* fields hold a valid entry.
- out_ready  input  1  writeback accepts the entry.
- out_result  output  N  buffered result.
- out_dest  output  REG_W  buffered destination tag.
- out_flags  output  4  buffered flags, bit order {N,Z,C,V}.
- status_flags  output  4  architectural NZCV register, same bit order.
- occupancy  output  2  number of entries held (0..2).

Behaviour:
- Reset:
  - rst is synchronous and active-high. While it is sampled high: out_valid=0, occupancy=0, status_flags=0, out_result/out_dest/out_flags=0.
  - in_ready=0 during reset. in_ready=1 in the first cycle after rst is deasserted.
  - Reset mid-operation discards all buffered entries; no flag commit happens in that cycle.
- Transfers:
  - Accept when in_valid && in_ready.
  - Retire when out_valid && out_ready.
- Storage is a main register M, which drives out_*, plus a skid register S.
- in_ready is registered and equals !S_full.
- Flag capture rule:
  - out_flags = {in_n, in_z, in_c, in_o}.
  - For opcodes 010 and 101, C and V are forced to 0 at capture.
- Latency and throughput: an entry accepted at edge k is visible on out_* after edge k (one cycle). Sustained throughput is one entry per cycle when out_ready=1.
- Occupancy cases at each edge:
  - M empty, accept: entry goes to M.
  - M full, retire, accept, S empty: new entry goes to M.
  - M full, no retire, accept: new entry goes to S; in_ready=0 next cycle.
  - M full, retire, S full: S moves to M and S empties. No accept is possible, since in_ready=0.
  - M full, retire, no accept, S empty: M empties; out_valid=0 next cycle.
- Order is always preserved (FIFO). S is never overwritten while full.
- occupancy tracks M_full + S_full after each edge.
- Status commit: on retire with the entry's set_flags=1, status_flags <= that entry's out_flags at the same edge. Entries with set_flags=0 leave status_flags unchanged.
- Output stability: out_* must stay stable while out_valid && !out_ready.
- Errors: none. in_valid while in_ready=0 is ignored, and upstream must hold its data.

Decomposition:
- Shared package `alu_pkg` holds:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_DIV=3'b101;
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - packed struct typedef alu_entry_t {result, dest, flags, set_flags}.
- No sub-module. M and S are two instances of alu_entry_t inside this module.
- The bench instantiates the existing `alu` upstream.

Test Plan:
- Basic capture: A=32, B=32, opcode 001, set_flags=1, dest=3, out_ready=1 -> next cycle out_result=0, out_flags=4'b0100, out_dest=3. status_flags=4'b0100 after retire.
- Back-pressure: out_ready=0, three back-to-back accepts (add 1+1, add 2+2, add 3+3) -> occupancy=2, in_ready=0 after the second. The third is held by the source. Releasing out_ready yields 2, 4, 6 in order.
- Multiply flag masking: A=100, B=2, opcode 010 -> out_result=200, out_flags C=0 and V=0 regardless of in_c/in_o.
- Carry and no-flag op: A=32'hFFFFFFFF, B=1, opcode 000, set_flags=1 -> out_flags=4'b0110 committed. A following div 50/3 with set_flags=0 -> out_result=16, status_flags stays 4'b0110.
- Reset mid-operation: with occupancy=2, assert rst one cycle -> out_valid=0, occupancy=0, status_flags=0. in_ready rises the cycle after rst falls.
- Simultaneous retire and accept with M full and S empty -> occupancy stays 1, new entry appears on out the next cycle.
